// File: rtl/input_conditioner_if.sv
// Switch/button bundle between the board pins, the conditioner and the pattern logic.
// master drives the raw pins and reads the conditioned levels/events; slave is the conditioner.
interface input_conditioner_if;
  logic [3:0] DIP;
  logic [3:0] PB;
  logic [3:0] dip_clean;
  logic [3:0] pb_clean;
  logic [3:0] pb_press;
  logic [3:0] pb_release;
  logic       dip_changed;
  logic       ready;

  modport master (
    output DIP, PB,
    input  dip_clean, pb_clean, pb_press, pb_release, dip_changed, ready
  );

  modport slave (
    input  DIP, PB,
    output dip_clean, pb_clean, pb_press, pb_release, dip_changed, ready
  );
endinterface

// File: rtl/input_conditioner.sv
// Switch front end: 2-flop sync and per-bit debounce for DIP[3:0]/PB[3:0],
// registered press/release/change pulses and a sticky startup ready flag.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int PB_ACTIVE_LOW   = 1,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input_conditioner_if.slave io
);
  localparam int NUM_LANES = 8;
  localparam int RW        = $clog2(DEBOUNCE_CYCLES + 2);

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] clean;
  logic [NUM_LANES-1:0] accept;
  logic [3:0]           press_q;
  logic [3:0]           release_q;
  logic                 dip_chg_q;
  logic                 ready_q;
  logic [RW-1:0]        rdy_cnt;

  // lanes 3:0 carry DIP, lanes 7:4 carry PB (optionally inverted so 1 = pressed)
  assign raw = {io.PB, io.DIP};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    input_conditioner_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CW              (CW),
      .INV             ((g >= 4) && (PB_ACTIVE_LOW != 0))
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[g]),
      .clean  (clean[g]),
      .accept (accept[g])
    );
  end

  // on acceptance the new level is the inverse of the current clean level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_q   <= '0;
      release_q <= '0;
      dip_chg_q <= 1'b0;
    end else begin
      press_q   <= accept[7:4] & ~clean[7:4];
      release_q <= accept[7:4] &  clean[7:4];
      dip_chg_q <= |accept[3:0];
    end
  end

  // counts edges since reset release; ready rises on edge DEBOUNCE_CYCLES+2 and sticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_cnt <= '0;
      ready_q <= 1'b0;
    end else if (!ready_q) begin
      if (rdy_cnt == RW'(DEBOUNCE_CYCLES + 1)) ready_q <= 1'b1;
      else                                     rdy_cnt <= rdy_cnt + 1'b1;
    end
  end

  assign io.dip_clean   = clean[3:0];
  assign io.pb_clean    = clean[7:4];
  assign io.pb_press    = press_q;
  assign io.pb_release  = release_q;
  assign io.dip_changed = dip_chg_q;
  assign io.ready       = ready_q;
endmodule

// One conditioned bit: sync chain holding the raw inactive level in reset, then a
// counter that must see DEBOUNCE_CYCLES consecutive differing samples before accepting.
module input_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1),
  parameter bit INV             = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic accept
);
  logic          s1, s2;
  logic          lvl;
  logic [CW-1:0] cnt;

  assign lvl    = s2 ^ INV;
  assign accept = (lvl != clean) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= INV;
      s2 <= INV;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (lvl == clean) begin
      cnt <= '0;
    end else if (accept) begin
      clean <= lvl;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner at DEBOUNCE_CYCLES=4, PB active low: directed scenarios
// with hand-derived expectations, then random stimulus against a sample-window model.
module tb_input_conditioner;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_conditioner_if bus();

  input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .PB_ACTIVE_LOW   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: a bit flips once the DC most recent synced samples (raw seen 2..DC+1 edges ago)
  // all differ from its current clean level
  logic [7:0] hist[$];
  logic [7:0] m_clean;
  logic [3:0] m_press, m_rel;
  logic       m_dchg, m_ready;
  int         m_edges;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back(8'h00);
    m_clean = '0; m_press = '0; m_rel = '0;
    m_dchg = 1'b0; m_ready = 1'b0; m_edges = 0;
  endfunction

  function automatic void model_step(logic [7:0] smp);
    logic [7:0] nxt, chg;
    logic       all_diff;
    hist.push_front(smp);
    void'(hist.pop_back());
    nxt = m_clean;
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k < DC + 2; k++) if (hist[k][i] == m_clean[i]) all_diff = 1'b0;
      if (all_diff) nxt[i] = ~m_clean[i];
    end
    chg     = nxt ^ m_clean;
    m_press = chg[7:4] & nxt[7:4];
    m_rel   = chg[7:4] & ~nxt[7:4];
    m_dchg  = |chg[3:0];
    m_clean = nxt;
    m_edges++;
    if (m_edges >= DC + 2) m_ready = 1'b1;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_step({~bus.PB, bus.DIP});
      #1;
    end
  endtask

  task automatic test_reset();
    logic [17:0] got;
    rst = 1'b0; bus.DIP = 4'b1001; bus.PB = 4'hF;
    model_reset();
    #12;
    got = {bus.dip_clean, bus.pb_clean, bus.pb_press, bus.pb_release, bus.dip_changed, bus.ready};
    n_chk++;
    if (got !== 18'h0) $display("FAIL reset_outputs got %h exp %h", got, 18'h0);
    else n_pass++;
  endtask

  task automatic test_startup_dip();
    @(posedge clk); #1; rst = 1'b1;
    step(5);
    n_chk++;
    if ({bus.dip_clean, bus.dip_changed, bus.ready} !== 6'b0)
      $display("FAIL startup_edge5 got %b exp %b", {bus.dip_clean, bus.dip_changed, bus.ready}, 6'b0);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.dip_clean, bus.dip_changed, bus.ready} !== 6'b1001_1_1)
      $display("FAIL startup_edge6 got %b exp %b", {bus.dip_clean, bus.dip_changed, bus.ready}, 6'b1001_1_1);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.dip_changed, bus.ready} !== 2'b01)
      $display("FAIL startup_edge7 got %b exp %b", {bus.dip_changed, bus.ready}, 2'b01);
    else n_pass++;
  endtask

  task automatic test_pb_glitch();
    logic [11:0] seen = '0;
    bus.PB = 4'b1110;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) bus.PB = 4'b1111;
      step(1);
      seen |= {bus.pb_clean, bus.pb_press, bus.pb_release};
    end
    n_chk++;
    if (seen !== 12'h0) $display("FAIL pb_glitch got %h exp %h", seen, 12'h0);
    else n_pass++;
  endtask

  task automatic test_pb_press_release();
    bus.PB = 4'b1011;
    step(5);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press} !== 8'h00)
      $display("FAIL press_early got %b exp %b", {bus.pb_clean, bus.pb_press}, 8'h00);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press, bus.pb_release} !== 12'b0100_0100_0000)
      $display("FAIL press_edge6 got %b exp %b", {bus.pb_clean, bus.pb_press, bus.pb_release}, 12'b0100_0100_0000);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press} !== 8'b0100_0000)
      $display("FAIL press_one_cycle got %b exp %b", {bus.pb_clean, bus.pb_press}, 8'b0100_0000);
    else n_pass++;
    step(3);
    bus.PB = 4'b1111;
    step(5);
    n_chk++;
    if ({bus.pb_clean, bus.pb_release} !== 8'b0100_0000)
      $display("FAIL release_early got %b exp %b", {bus.pb_clean, bus.pb_release}, 8'b0100_0000);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press, bus.pb_release} !== 12'b0000_0000_0100)
      $display("FAIL release_edge6 got %b exp %b", {bus.pb_clean, bus.pb_press, bus.pb_release}, 12'b0000_0000_0100);
    else n_pass++;
    step(1);
    n_chk++;
    if (bus.pb_release !== 4'b0000) $display("FAIL release_one_cycle got %b exp %b", bus.pb_release, 4'b0000);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bus.PB = 4'b0101;
    step(5);
    n_chk++;
    if (bus.pb_press !== 4'b0000) $display("FAIL simul_early got %b exp %b", bus.pb_press, 4'b0000);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press} !== 8'b1010_1010)
      $display("FAIL simul_press got %b exp %b", {bus.pb_clean, bus.pb_press}, 8'b1010_1010);
    else n_pass++;
    step(1);
    n_chk++;
    if (bus.pb_press !== 4'b0000) $display("FAIL simul_one_cycle got %b exp %b", bus.pb_press, 4'b0000);
    else n_pass++;
    bus.PB = 4'b1111;
    step(6);
    n_chk++;
    if ({bus.pb_clean, bus.pb_release} !== 8'b0000_1010)
      $display("FAIL simul_release got %b exp %b", {bus.pb_clean, bus.pb_release}, 8'b0000_1010);
    else n_pass++;
    step(2);
  endtask

  task automatic test_dip_bounce();
    int pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) bus.DIP = ~bus.DIP;
      step(1);
      if (bus.dip_changed) pulses++;
    end
    n_chk++;
    if ({pulses, bus.dip_clean} !== {32'd0, 4'b1001})
      $display("FAIL bounce_hold got pulses=%0d clean=%b exp pulses=0 clean=1001", pulses, bus.dip_clean);
    else n_pass++;
    bus.DIP = 4'b0110;
    step(5);
    if (bus.dip_changed) pulses++;
    step(1);
    n_chk++;
    if ({bus.dip_clean, bus.dip_changed} !== 5'b0110_1)
      $display("FAIL bounce_rest got %b exp %b", {bus.dip_clean, bus.dip_changed}, 5'b0110_1);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (bus.dip_changed) pulses++;
      step(1);
    end
    n_chk++;
    if (pulses !== 1) $display("FAIL bounce_pulse_count got %0d exp 1", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    logic [17:0] got;
    bus.PB = 4'b0111;
    step(4);
    #2 rst = 1'b0;
    #1;
    model_reset();
    got = {bus.dip_clean, bus.pb_clean, bus.pb_press, bus.pb_release, bus.dip_changed, bus.ready};
    n_chk++;
    if (got !== 18'h0) $display("FAIL midcount_async_reset got %h exp %h", got, 18'h0);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    step(5);
    n_chk++;
    if ({bus.pb_clean, bus.dip_clean, bus.ready} !== 9'b0)
      $display("FAIL midcount_edge5 got %b exp %b", {bus.pb_clean, bus.dip_clean, bus.ready}, 9'b0);
    else n_pass++;
    step(1);
    n_chk++;
    if ({bus.pb_clean, bus.pb_press, bus.dip_clean, bus.dip_changed, bus.ready} !== 14'b1000_1000_0110_1_1)
      $display("FAIL midcount_edge6 got %b exp %b",
               {bus.pb_clean, bus.pb_press, bus.dip_clean, bus.dip_changed, bus.ready}, 14'b1000_1000_0110_1_1);
    else n_pass++;
    bus.PB = 4'b1111;
    step(8);
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    int hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        bus.DIP = 4'($urandom);
        bus.PB  = 4'($urandom);
        hold    = $urandom_range(1, DC + 3);
      end
      hold--;
      step(1);
      got = {bus.dip_clean, bus.pb_clean, bus.pb_press, bus.pb_release, bus.dip_changed, bus.ready};
      exp = {m_clean[3:0], m_clean[7:4], m_press, m_rel, m_dchg, m_ready};
      n_chk++;
      if (got !== exp) $display("FAIL random_cycle%0d got %b exp %b", c, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_startup_dip();
    test_pb_glitch();
    test_pb_press_release();
    test_simultaneous();
    test_dip_bounce();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
